// File: rtl/buffer_pkg.sv
// Shared definitions for the circular Buffer and its sequencer (buffer_ctrl).
//   state_t  : sequencer debug state (S_IDLE, S_ACTIVE, S_FULL)
//   DEF_*    : default depth / write burst / read burst shared with the Buffer
//   addr_w() : address width for a given depth
//   cnt_w()  : occupancy width (must hold 0..SIZE inclusive)
package buffer_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FULL   = 2'd2
  } state_t;

  localparam int DEF_SIZE = 16;
  localparam int DEF_K    = 8;
  localparam int DEF_J    = 4;

  function automatic int addr_w(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  function automatic int cnt_w(input int size);
    return addr_w(size) + 1;
  endfunction

endpackage

// File: rtl/buf_ptr_wrap.sv
// Circular pointer that advances by a fixed STEP modulo SIZE.
//   clk  in   clock
//   rst  in   asynchronous active-high reset (pointer -> 0)
//   clr  in   synchronous clear (pointer -> 0)
//   adv  in   advance by STEP at the next edge
//   ptr  out  current pointer, BIT bits
// SIZE is a power of two, so dropping the carry out of a BIT-bit add is the modulo.
module buf_ptr_wrap
  import buffer_pkg::*;
#(
  parameter int SIZE = DEF_SIZE,
  parameter int STEP = 1,
  parameter int BIT  = addr_w(SIZE)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           adv,
  output logic [BIT-1:0] ptr
);

  localparam logic [BIT-1:0] STEP_M = BIT'(STEP % SIZE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      ptr <= '0;
    else if (clr) ptr <= '0;
    else if (adv) ptr <= ptr + STEP_M;
  end

endmodule

// File: rtl/buffer_ctrl.sv
// Sequencer for the circular Buffer (K-word parallel write, J-word parallel read).
// Owns write/read base addresses and the occupancy count; carries no data.
//   clk, rst   clock, asynchronous active-high reset
//   flush      (only with BUFFER_CTRL_FLUSH_EN) synchronous clear, overrides wr/rd
//   in_valid   producer offers K words         in_ready  free >= K
//   out_valid  count >= J                       out_ready consumer takes J words
//   ld         Buffer write strobe (in_valid & in_ready)
//   write_add, read_add  Buffer base addresses
//   count      stored words 0..SIZE; full / empty flags
//   state      debug view of the sequencer state (S_IDLE/S_ACTIVE/S_FULL)
// Optional feature macro: BUFFER_CTRL_FLUSH_EN.
module buffer_ctrl
  import buffer_pkg::*;
#(
  parameter int SIZE = DEF_SIZE,
  parameter int K    = DEF_K,
  parameter int J    = DEF_J,
  parameter int BIT  = addr_w(SIZE)
) (
  input  logic           clk,
  input  logic           rst,
`ifdef BUFFER_CTRL_FLUSH_EN
  input  logic           flush,
`endif
  input  logic           in_valid,
  output logic           in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           ld,
  output logic [BIT-1:0] write_add,
  output logic [BIT-1:0] read_add,
  output logic [BIT:0]   count,
  output logic           full,
  output logic           empty,
  output logic [1:0]     state
);

  // Occupancy arithmetic is carried two bits wider than the address so that
  // count + K can never wrap before the result is truncated.
  localparam int CW = BIT + 2;
  localparam logic [CW-1:0] SIZE_W = CW'(SIZE);
  localparam logic [CW-1:0] K_W    = CW'(K);
  localparam logic [CW-1:0] J_W    = CW'(J);

  logic          flush_i;
  logic          wr;
  logic          rd;
  logic [CW-1:0] count_x;
  logic [CW-1:0] free_x;
  logic [CW-1:0] count_nxt;
  state_t        state_q;

`ifdef BUFFER_CTRL_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cur,
                                               input logic wr_f, input logic rd_f);
    return cur + (wr_f ? K_W : '0) - (rd_f ? J_W : '0);
  endfunction

  function automatic state_t state_of(input logic [CW-1:0] cnt);
    if ((SIZE_W - cnt) < K_W) return S_FULL;
    else if (cnt >= J_W)      return S_ACTIVE;
    else                      return S_IDLE;
  endfunction

  // Handshake flags come only from the registered count, so a read in the
  // same cycle never opens room for a write.
  assign count_x   = {1'b0, count};
  assign free_x    = SIZE_W - count_x;
  assign in_ready  = (free_x >= K_W);
  assign out_valid = (count_x >= J_W);
  assign full      = (count_x == SIZE_W);
  assign empty     = (count == '0);

  assign wr        = in_valid & in_ready & ~flush_i;
  assign rd        = out_valid & out_ready & ~flush_i;
  assign ld        = wr;
  assign count_nxt = next_count(count_x, wr, rd);
  assign state     = state_q;

  buf_ptr_wrap #(.SIZE(SIZE), .STEP(K), .BIT(BIT)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush_i),
    .adv (wr),
    .ptr (write_add)
  );

  buf_ptr_wrap #(.SIZE(SIZE), .STEP(J), .BIT(BIT)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush_i),
    .adv (rd),
    .ptr (read_add)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      state_q <= S_IDLE;
    end else if (flush_i) begin
      count   <= '0;
      state_q <= S_IDLE;
    end else begin
      count   <= count_nxt[BIT:0];
      state_q <= state_of(count_nxt);
    end
  end

endmodule

// File: tb/tb_buffer_ctrl.sv
// Scoreboard bench for buffer_ctrl (SIZE=16, K=8, J=4).
// Stimulus pushes hand-computed expectations; the monitor pops and compares them
// one cycle later (after the edge), or immediately for asynchronous-reset checks.
module tb_buffer_ctrl;
  import buffer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, ld, full, empty;
  logic [3:0] write_add, read_add;
  logic [4:0] count;
  logic [1:0] state;
`ifdef BUFFER_CTRL_FLUSH_EN
  logic       flush = 1'b0;
`endif

  buffer_ctrl #(.SIZE(16), .K(8), .J(4)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef BUFFER_CTRL_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ld        (ld),
    .write_add (write_add),
    .read_add  (read_add),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      tag;
    logic       ld;
    logic [3:0] wa;
    logic [3:0] ra;
    logic [4:0] cnt;
    logic [1:0] st;
  } exp_t;

  exp_t q[$];
  exp_t imm_q[$];
  event ev_imm;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic ld_s = 1'b0;

  task automatic chk(input string tag, input string fld, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s.%s: got %0d expected %0d", tag, fld, act, exp);
    end
  endtask

  // Derived flags follow directly from the hand-stated count for this geometry.
  task automatic compare(input exp_t e, input logic ld_act);
    chk(e.tag, "ld",        int'(ld_act),    int'(e.ld));
    chk(e.tag, "write_add", int'(write_add), int'(e.wa));
    chk(e.tag, "read_add",  int'(read_add),  int'(e.ra));
    chk(e.tag, "count",     int'(count),     int'(e.cnt));
    chk(e.tag, "in_ready",  int'(in_ready),  (16 - int'(e.cnt)) >= 8 ? 1 : 0);
    chk(e.tag, "out_valid", int'(out_valid), int'(e.cnt) >= 4 ? 1 : 0);
    chk(e.tag, "full",      int'(full),      int'(e.cnt) == 16 ? 1 : 0);
    chk(e.tag, "empty",     int'(empty),     int'(e.cnt) == 0 ? 1 : 0);
    chk(e.tag, "state",     int'(state),     int'(e.st));
  endtask

  // Monitor: ld is sampled mid-cycle (inputs settle 2 ns after the edge),
  // registered outputs 1 ns after the edge that should have updated them.
  always @(negedge clk) ld_s = ld;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t e;
        e = q.pop_front();
        compare(e, ld_s);
      end
    end
  end

  initial begin
    forever begin
      @(ev_imm);
      while (imm_q.size() > 0) begin
        exp_t e;
        e = imm_q.pop_front();
        compare(e, ld);
      end
    end
  end

  task automatic push_now(input string tag, input logic [4:0] cnt);
    exp_t e;
    e.cyc = cyc; e.tag = tag; e.ld = 1'b0; e.wa = 4'd0; e.ra = 4'd0;
    e.cnt = cnt; e.st = S_IDLE;
    imm_q.push_back(e);
    -> ev_imm;
  endtask

  // One clock of stimulus; the expectation describes the beat's ld and the
  // register values after the following edge.
  task automatic beat(input logic iv, input logic ordy, input string tag,
                      input logic eld, input logic [3:0] wa, input logic [3:0] ra,
                      input logic [4:0] cnt, input logic [1:0] st);
    exp_t e;
    @(posedge clk);
    #2;
    in_valid  = iv;
    out_ready = ordy;
    e.cyc = cyc + 1; e.tag = tag; e.ld = eld; e.wa = wa; e.ra = ra;
    e.cnt = cnt; e.st = st;
    q.push_back(e);
  endtask

  task automatic idle_inputs();
    @(posedge clk);
    #2;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  // Reset pulse placed between clock edges; outputs must clear without an edge.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #2;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    push_now(tag, 5'd0);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // 1. reset
    #1 rst = 1'b1;
    #11 rst = 1'b0;
    push_now("reset", 5'd0);

    // 2. single write
    beat(1'b1, 1'b0, "write1",  1'b1, 4'd8, 4'd0, 5'd8,  S_ACTIVE);
    // 3. fill, then a held write while full is ignored
    beat(1'b1, 1'b0, "write2",  1'b1, 4'd0, 4'd0, 5'd16, S_FULL);
    beat(1'b1, 1'b0, "wr_full", 1'b0, 4'd0, 4'd0, 5'd16, S_FULL);
    // 4. drain from full, read pointer wraps
    beat(1'b0, 1'b1, "rd1",     1'b0, 4'd0, 4'd4,  5'd12, S_FULL);
    beat(1'b0, 1'b1, "rd2",     1'b0, 4'd0, 4'd8,  5'd8,  S_ACTIVE);
    beat(1'b0, 1'b1, "rd3",     1'b0, 4'd0, 4'd12, 5'd4,  S_ACTIVE);
    beat(1'b0, 1'b1, "rd4",     1'b0, 4'd0, 4'd0,  5'd0,  S_IDLE);
    // read request while empty is ignored
    beat(1'b0, 1'b1, "rd_empty", 1'b0, 4'd0, 4'd0, 5'd0,  S_IDLE);

    // 5. simultaneous read and write from count=8, wa=8, ra=0
    async_reset("reset_mid0");
    beat(1'b1, 1'b0, "pre_sim", 1'b1, 4'd8, 4'd0, 5'd8,  S_ACTIVE);
    beat(1'b1, 1'b1, "sim",     1'b1, 4'd0, 4'd4, 5'd12, S_FULL);
    // in_ready=0 at count 12 even with a read: only the read fires
    beat(1'b1, 1'b1, "sim_gate", 1'b0, 4'd0, 4'd8, 5'd8, S_ACTIVE);
    beat(1'b1, 1'b0, "refill",  1'b1, 4'd8, 4'd8, 5'd16, S_FULL);
    beat(1'b0, 1'b1, "rd12",    1'b0, 4'd8, 4'd12, 5'd12, S_FULL);
    idle_inputs();

    // 6. async reset at count=12
    async_reset("reset_mid");

`ifdef BUFFER_CTRL_FLUSH_EN
    beat(1'b1, 1'b0, "pre_flush", 1'b1, 4'd8, 4'd0, 5'd8, S_ACTIVE);
    @(posedge clk);
    #2;
    flush = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    begin
      exp_t e;
      e.cyc = cyc + 1; e.tag = "flush"; e.ld = 1'b0; e.wa = 4'd0; e.ra = 4'd0;
      e.cnt = 5'd0; e.st = S_IDLE;
      q.push_back(e);
    end
    @(posedge clk);
    #2;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
`endif

    // drain the scoreboard with a bounded wait
    begin
      int guard;
      guard = 0;
      while ((q.size() > 0 || imm_q.size() > 0) && guard < 10) begin
        @(posedge clk);
        guard++;
      end
      #2;
      if (q.size() > 0 || imm_q.size() > 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL drain: got %0d pending expected 0", q.size() + imm_q.size());
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
